// File: rtl/na_seq_pkg.sv
// ---------------------------------------------------------------------------
// na_seq_pkg
// Shared types and constants for the nucleic-acid extraction sequencer.
//   state_e : sub-state of the current reagent step (IDLE/FILL/INCUB/DRAIN)
//   phase_e : protocol phase encoding as driven on the phase output
//   PUMP_*  : peristaltic valve patterns p1..p3 (1 = valve open)
// ---------------------------------------------------------------------------
package na_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_INCUB = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_LYSIS = 2'd1,
    PH_WASH  = 2'd2,
    PH_ELUTE = 2'd3
  } phase_e;

  localparam logic [2:0] PUMP_OFF = 3'b000;
  localparam logic [2:0] PUMP_S0  = 3'b011;
  localparam logic [2:0] PUMP_S1  = 3'b110;
  localparam logic [2:0] PUMP_S2  = 3'b101;

  // Valve pattern for a given step of the three-step peristaltic cycle.
  function automatic logic [2:0] pump_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    return PUMP_S0;
      2'd1:    return PUMP_S1;
      default: return PUMP_S2;
    endcase
  endfunction

endpackage

// File: rtl/na_pump_driver.sv
// ---------------------------------------------------------------------------
// na_pump_driver
// Step divider and pattern rotation for the 3-valve peristaltic pump.
// Each pattern is held STEP_CLKS clocks; three steps make one pump cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_run         : count and drive the pattern; when low the pump is closed
//                   and the divider is held at the start of a cycle
//   i_restart     : next clock begins again at the first pattern step
//   o_pump[2:0]   : valve pattern p1..p3 (3'b000 when not running)
//   o_cycle_tick  : high on the last clock of each complete pump cycle
// ---------------------------------------------------------------------------
module na_pump_driver
  import na_seq_pkg::*;
#(
  parameter int STEP_CLKS = 1000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_restart,
  output logic [2:0] o_pump,
  output logic       o_cycle_tick
);

  logic [CNT_W-1:0] r_step_cnt;
  logic [1:0]       r_step_idx;
  logic             w_step_last;

  assign w_step_last  = (r_step_cnt == CNT_W'(STEP_CLKS - 1));
  assign o_cycle_tick = i_run && w_step_last && (r_step_idx == 2'd2);
  assign o_pump       = i_run ? pump_pattern(r_step_idx) : PUMP_OFF;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_step_idx <= 2'd0;
    end else if (!i_run || i_restart) begin
      r_step_cnt <= '0;
      r_step_idx <= 2'd0;
    end else if (w_step_last) begin
      r_step_cnt <= '0;
      r_step_idx <= (r_step_idx == 2'd2) ? 2'd0 : r_step_idx + 2'd1;
    end else begin
      r_step_cnt <= r_step_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/na_extract_sequencer.sv
// ---------------------------------------------------------------------------
// na_extract_sequencer
// Protocol sequencer for an N_CH-channel nucleic-acid extraction array.
// Runs LYSIS -> WASH -> ELUTE over the enabled channels; every reagent step
// is FILL -> INCUBATE -> DRAIN, each sub-state lasting cyc*3*STEP_CLKS clocks.
// Elution drains one channel at a time into its collection outlet.
// All valve outputs: 1 = valve open. All outputs decode registered state.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin protocol (honoured in IDLE only)
//   abort            : return to IDLE with every valve closed (beats start)
//   chan_en[N_CH]    : channel enable mask, captured on start
//   busy, done       : running flag, one-cycle completion pulse
//   phase[1:0]       : 0 idle, 1 lysis, 2 wash, 3 elute
//   lysis/wash/elute_ctl, loop_exit_ctl, bead_trap_ctl, waste_ctl : valves
//   vertical_ctl[N_CH], collection_ctl[N_CH] : per-channel valves
//   pump[2:0]        : peristaltic valves p1..p3
// Build option: define NA_SEQ_MIX_EN to run the pump (loop mixing) during
// INCUBATE; otherwise the pump is held closed there with identical timing.
// ---------------------------------------------------------------------------
module na_extract_sequencer
  import na_seq_pkg::*;
#(
  parameter int N_CH      = 9,
  parameter int STEP_CLKS = 1000,
  parameter int FILL_CYC  = 16,
  parameter int INCUB_CYC = 64,
  parameter int DRAIN_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] chan_en,
  output logic            busy,
  output logic            done,
  output logic [1:0]      phase,
  output logic            lysis_ctl,
  output logic            wash_ctl,
  output logic            elute_ctl,
  output logic [N_CH-1:0] vertical_ctl,
  output logic            loop_exit_ctl,
  output logic            bead_trap_ctl,
  output logic            waste_ctl,
  output logic [N_CH-1:0] collection_ctl,
  output logic [2:0]      pump
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e           r_state,   w_nxt_state;
  phase_e           r_phase,   w_nxt_phase;
  logic [N_CH-1:0]  r_mask,    w_nxt_mask;
  logic [CH_W-1:0]  r_chan,    w_nxt_chan;
  logic [CNT_W-1:0] r_cyc_cnt, w_nxt_cyc;
  logic             r_done,    w_nxt_done;

  logic             w_run;
  logic             w_advance;
  logic             w_tick;
  logic [2:0]       w_pump;
  logic [CNT_W-1:0] w_cyc_last;
  logic             w_sub_last;
  int               w_after;
  logic             w_nxt_found;
  logic [CH_W-1:0]  w_nxt_idx;
  logic [N_CH-1:0]  w_chan_onehot;

  assign w_run = (r_state != ST_IDLE);

  // The divider restarts on every sub-state entry (including the hop to the
  // next elution channel) so each sub-state opens on pattern 3'b011.
  na_pump_driver #(
    .STEP_CLKS (STEP_CLKS),
    .CNT_W     (CNT_W)
  ) u_pump (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run        (w_run),
    .i_restart    (w_advance),
    .o_pump       (w_pump),
    .o_cycle_tick (w_tick)
  );

  // Last pump-cycle index of the current sub-state.
  always_comb begin
    case (r_state)
      ST_FILL:  w_cyc_last = CNT_W'(FILL_CYC - 1);
      ST_INCUB: w_cyc_last = CNT_W'(INCUB_CYC - 1);
      default:  w_cyc_last = CNT_W'(DRAIN_CYC - 1);
    endcase
  end

  assign w_sub_last = w_tick && (r_cyc_cnt == w_cyc_last);

  // Next enabled channel strictly above w_after; entering DRAIN from INCUB
  // searches from -1, which yields the lowest enabled channel.
  assign w_after = (r_state == ST_DRAIN) ? int'(r_chan) : -1;

  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > w_after)) begin
        w_nxt_found = 1'b1;
        w_nxt_idx   = CH_W'(i);
      end
    end
  end

  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_mask  = r_mask;
    w_nxt_chan  = r_chan;
    w_nxt_cyc   = r_cyc_cnt;
    w_nxt_done  = 1'b0;
    w_advance   = 1'b0;

    if (abort) begin
      w_nxt_state = ST_IDLE;
      w_nxt_phase = PH_IDLE;
      w_nxt_cyc   = '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        if (chan_en == '0) begin
          // Nothing to process: complete immediately without going busy.
          w_nxt_done = 1'b1;
        end else begin
          w_nxt_state = ST_FILL;
          w_nxt_phase = PH_LYSIS;
          w_nxt_mask  = chan_en;
          w_nxt_cyc   = '0;
        end
      end
    end else if (w_tick) begin
      if (w_sub_last) begin
        w_advance = 1'b1;
        w_nxt_cyc = '0;
        case (r_state)
          ST_FILL: w_nxt_state = ST_INCUB;
          ST_INCUB: begin
            w_nxt_state = ST_DRAIN;
            if (r_phase == PH_ELUTE) w_nxt_chan = w_nxt_idx;
          end
          ST_DRAIN: begin
            if (r_phase != PH_ELUTE) begin
              w_nxt_state = ST_FILL;
              w_nxt_phase = (r_phase == PH_LYSIS) ? PH_WASH : PH_ELUTE;
            end else if (w_nxt_found) begin
              w_nxt_chan = w_nxt_idx;
            end else begin
              w_nxt_state = ST_IDLE;
              w_nxt_phase = PH_IDLE;
              w_nxt_done  = 1'b1;
            end
          end
          default: w_nxt_state = ST_IDLE;
        endcase
      end else begin
        w_nxt_cyc = r_cyc_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_phase   <= PH_IDLE;
      r_mask    <= '0;
      r_chan    <= '0;
      r_cyc_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_phase   <= w_nxt_phase;
      r_mask    <= w_nxt_mask;
      r_chan    <= w_nxt_chan;
      r_cyc_cnt <= w_nxt_cyc;
      r_done    <= w_nxt_done;
    end
  end

  always_comb begin
    w_chan_onehot         = '0;
    w_chan_onehot[r_chan] = 1'b1;
  end

  assign busy  = w_run;
  assign done  = r_done;
  assign phase = r_phase;

  // Valve decode; IDLE leaves everything closed.
  always_comb begin
    lysis_ctl      = 1'b0;
    wash_ctl       = 1'b0;
    elute_ctl      = 1'b0;
    vertical_ctl   = '0;
    loop_exit_ctl  = 1'b0;
    bead_trap_ctl  = 1'b0;
    waste_ctl      = 1'b0;
    collection_ctl = '0;
    pump           = w_pump;
    case (r_state)
      ST_FILL: begin
        lysis_ctl    = (r_phase == PH_LYSIS);
        wash_ctl     = (r_phase == PH_WASH);
        elute_ctl    = (r_phase == PH_ELUTE);
        vertical_ctl = r_mask;
      end
      ST_INCUB: begin
        vertical_ctl  = r_mask;
        bead_trap_ctl = 1'b1;
`ifdef NA_SEQ_MIX_EN
        pump          = w_pump;
`else
        pump          = PUMP_OFF;
`endif
      end
      ST_DRAIN: begin
        if (r_phase == PH_ELUTE) begin
          collection_ctl = w_chan_onehot;
          vertical_ctl   = w_chan_onehot;
        end else begin
          loop_exit_ctl = 1'b1;
          waste_ctl     = 1'b1;
          vertical_ctl  = r_mask;
        end
      end
      default: pump = PUMP_OFF;
    endcase
  end

endmodule

// File: tb/tb_na_extract_sequencer.sv
// ---------------------------------------------------------------------------
// tb_na_extract_sequencer
// Directed bench for na_extract_sequencer with N_CH=4, STEP_CLKS=2, FILL=2,
// INCUB=3, DRAIN=2 (one pump cycle = 6 clocks). Inputs are driven and
// outputs sampled on the falling edge. Expected waveforms come from a
// hand-derived protocol timeline indexed by clocks since start.
// ---------------------------------------------------------------------------
module tb_na_extract_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] chan_en;
  logic       busy;
  logic       done;
  logic [1:0] phase;
  logic       lysis_ctl;
  logic       wash_ctl;
  logic       elute_ctl;
  logic [3:0] vertical_ctl;
  logic       loop_exit_ctl;
  logic       bead_trap_ctl;
  logic       waste_ctl;
  logic [3:0] collection_ctl;
  logic [2:0] pump;

  int n_checks = 0;
  int n_pass   = 0;

  na_extract_sequencer #(
    .N_CH      (4),
    .STEP_CLKS (2),
    .FILL_CYC  (2),
    .INCUB_CYC (3),
    .DRAIN_CYC (2),
    .CNT_W     (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .chan_en        (chan_en),
    .busy           (busy),
    .done           (done),
    .phase          (phase),
    .lysis_ctl      (lysis_ctl),
    .wash_ctl       (wash_ctl),
    .elute_ctl      (elute_ctl),
    .vertical_ctl   (vertical_ctl),
    .loop_exit_ctl  (loop_exit_ctl),
    .bead_trap_ctl  (bead_trap_ctl),
    .waste_ctl      (waste_ctl),
    .collection_ctl (collection_ctl),
    .pump           (pump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, done, phase, lysis, wash, elute, vertical, loop_exit, bead_trap,
  //  waste, collection, pump}
  function automatic logic [20:0] dut_vec();
    return {busy, done, phase, lysis_ctl, wash_ctl, elute_ctl, vertical_ctl,
            loop_exit_ctl, bead_trap_ctl, waste_ctl, collection_ctl, pump};
  endfunction

  // Protocol timeline, j = clocks since the first busy cycle:
  //   lysis 0..41, wash 42..83 (fill 12, incub 18, drain 12 each),
  //   elute fill 84..95, incub 96..113, then 12 clocks per enabled channel.
  function automatic int run_len(input logic [3:0] m);
    int pop;
    pop = 0;
    for (int i = 0; i < 4; i++) if (m[i]) pop++;
    return 114 + 12 * pop;
  endfunction

  function automatic logic [20:0] exp_vec(input int j, input logic [3:0] m);
    logic       e_busy, e_done, e_lys, e_wsh, e_elu, e_lp, e_bt, e_wst;
    logic [1:0] e_ph;
    logic [3:0] e_vert, e_coll;
    logic [2:0] e_pmp;
    int         r, nth, seen, total;
    e_busy = 1'b0; e_done = 1'b0; e_lys = 1'b0; e_wsh = 1'b0; e_elu = 1'b0;
    e_lp = 1'b0; e_bt = 1'b0; e_wst = 1'b0; e_ph = 2'd0;
    e_vert = 4'd0; e_coll = 4'd0; e_pmp = 3'b000;
    total = run_len(m);
    if (j == total) begin
      e_done = 1'b1;
    end else if (j >= 0 && j < total) begin
      e_busy = 1'b1;
      if (j < 84) begin
        e_ph = (j < 42) ? 2'd1 : 2'd2;
        r    = j % 42;
      end else begin
        e_ph = 2'd3;
        r    = j - 84;
      end
      case ((j / 2) % 3)
        0:       e_pmp = 3'b011;
        1:       e_pmp = 3'b110;
        default: e_pmp = 3'b101;
      endcase
      if (r < 12) begin
        e_vert = m;
        e_lys  = (e_ph == 2'd1);
        e_wsh  = (e_ph == 2'd2);
        e_elu  = (e_ph == 2'd3);
      end else if (r < 30) begin
        e_vert = m;
        e_bt   = 1'b1;
`ifndef NA_SEQ_MIX_EN
        e_pmp  = 3'b000;
`endif
      end else if (e_ph != 2'd3) begin
        e_vert = m;
        e_lp   = 1'b1;
        e_wst  = 1'b1;
      end else begin
        nth  = (r - 30) / 12;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
          if (m[i]) begin
            if (seen == nth) e_coll[i] = 1'b1;
            seen++;
          end
        end
        e_vert = e_coll;
      end
    end
    return {e_busy, e_done, e_ph, e_lys, e_wsh, e_elu, e_vert,
            e_lp, e_bt, e_wst, e_coll, e_pmp};
  endfunction

  // Pulse start for one clock; returns on the falling edge of the first
  // busy cycle (j = 0).
  task automatic do_start(input logic [3:0] m);
    @(negedge clk);
    start   = 1'b1;
    chan_en = m;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Full protocol checked cycle by cycle through the done pulse and the
  // first idle cycle after it. With disturb set, start is re-pulsed and
  // chan_en inverted while running.
  task automatic run_protocol(input string name, input logic [3:0] m,
                              input bit disturb);
    int total;
    logic [20:0] got, exp;
    total = run_len(m);
    do_start(m);
    for (int j = 0; j <= total + 1; j++) begin
      got = dut_vec();
      exp = exp_vec(j, m);
      n_checks++;
      if (got !== exp)
        $display("FAIL %s j=%0d got=%b exp=%b", name, j, got, exp);
      else
        n_pass++;
      if (disturb) begin
        if (j == 5 || j == 50 || j == 100) begin
          start   = 1'b1;
          chan_en = ~m;
        end else begin
          start = 1'b0;
        end
        if (j == 120) chan_en = 4'b0000;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chan_en = 4'b0000;
    repeat (3) @(negedge clk);
    got = dut_vec();
    n_checks++;
    if (got !== 21'd0) $display("FAIL reset_held got=%b exp=%b", got, 21'd0);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = dut_vec();
    n_checks++;
    if (got !== 21'd0) $display("FAIL reset_release got=%b exp=%b", got, 21'd0);
    else n_pass++;
  endtask

  task automatic test_pump_trace();
    logic [2:0] trace [6];
    trace[0] = 3'b011; trace[1] = 3'b011; trace[2] = 3'b110;
    trace[3] = 3'b110; trace[4] = 3'b101; trace[5] = 3'b101;
    n_checks++;
    if (pump !== 3'b000) $display("FAIL pump_idle got=%b exp=000", pump);
    else n_pass++;
    do_start(4'b0001);
    for (int j = 0; j < 12; j++) begin
      n_checks++;
      if (pump !== trace[j % 6] || lysis_ctl !== 1'b1)
        $display("FAIL pump_trace j=%0d got=%b lysis=%b exp=%b lysis=1",
                 j, pump, lysis_ctl, trace[j % 6]);
      else
        n_pass++;
      @(negedge clk);
    end
    do_abort();
    n_checks++;
    if (dut_vec() !== 21'd0) $display("FAIL pump_abort got=%b exp=0", dut_vec());
    else n_pass++;
  endtask

  task automatic test_incub_pump();
    logic [2:0] exp_p;
`ifdef NA_SEQ_MIX_EN
    exp_p = 3'b110;
`else
    exp_p = 3'b000;
`endif
    do_start(4'b0010);
    repeat (14) @(negedge clk);
    // j = 14: lysis INCUBATE, second pump step
    n_checks++;
    if (pump !== exp_p || bead_trap_ctl !== 1'b1)
      $display("FAIL incub_pump got=%b trap=%b exp=%b trap=1",
               pump, bead_trap_ctl, exp_p);
    else
      n_pass++;
    do_abort();
  endtask

  task automatic test_abort();
    logic [20:0] got;
    int          bad;
    do_start(4'b0101);
    repeat (60) @(negedge clk);
    // j = 60: wash INCUBATE
    n_checks++;
    if (phase !== 2'd2 || bead_trap_ctl !== 1'b1)
      $display("FAIL abort_pre phase=%0d trap=%b exp phase=2 trap=1",
               phase, bead_trap_ctl);
    else
      n_pass++;
    start = 1'b1;  // abort must win over a coincident start
    do_abort();
    start = 1'b0;
    got = dut_vec();
    n_checks++;
    if (got !== 21'd0) $display("FAIL abort_next got=%b exp=0", got);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort_quiet bad_cycles=%0d exp=0", bad);
    else n_pass++;
    run_protocol("abort_rerun", 4'b1010, 1'b0);
  endtask

  task automatic test_zero_mask();
    logic [20:0] got, exp;
    int          bad;
    exp     = 21'd0;
    exp[19] = 1'b1;
    do_start(4'b0000);
    got = dut_vec();
    n_checks++;
    if (got !== exp) $display("FAIL zero_done got=%b exp=%b", got, exp);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dut_vec() !== 21'd0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL zero_quiet bad_cycles=%0d exp=0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    run_protocol("full_0101", 4'b0101, 1'b0);
    test_pump_trace();
    test_incub_pump();
    test_abort();
    test_zero_mask();
    run_protocol("busy_disturb", 4'b0101, 1'b1);
    run_protocol("full_1111", 4'b1111, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
